// File: rtl/pc_seq_if.sv
// pc_seq_if: PC control strobes, run handshake and sequencer outputs for pc_sequencer.
// run_cycles exists only when PC_SEQ_PERF_CNT_EN is defined.
interface pc_seq_if #(
  parameter int PC_W   = 12,
  parameter int VLEN_W = 8
);
  logic              start;
  logic [PC_W-1:0]   end_pc;
  logic              clken_PC;
  logic              load_PC;
  logic              incr_PC;
  logic [PC_W-1:0]   load_value_PC;
  logic              is_not_vect;
  logic [VLEN_W-1:0] vect_len;
  logic [PC_W-1:0]   pc;
  logic              imem_rd_en;
  logic [VLEN_W-1:0] elem_idx;
  logic              done_auto_incr;
  logic              busy;
  logic              done;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0]       run_cycles;
`endif
  modport master (
    output start, end_pc, clken_PC, load_PC, incr_PC, load_value_PC, is_not_vect, vect_len,
    input  pc, imem_rd_en, elem_idx, done_auto_incr, busy, done
`ifdef PC_SEQ_PERF_CNT_EN
    , input run_cycles
`endif
  );
  modport slave (
    input  start, end_pc, clken_PC, load_PC, incr_PC, load_value_PC, is_not_vect, vect_len,
    output pc, imem_rd_en, elem_idx, done_auto_incr, busy, done
`ifdef PC_SEQ_PERF_CNT_EN
    , output run_cycles
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, vector element counter and start/done run handshake.
// Optional run-cycle counter enabled by PC_SEQ_PERF_CNT_EN.
module pc_sequencer #(
  parameter int PC_W     = 12,
  parameter int VLEN_W   = 8,
  parameter int START_PC = 0
) (
  input logic    clk,
  input logic    rst,
  pc_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);
  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, end_pc_q, end_pc_d;
  logic [VLEN_W-1:0] elem_q, elem_d, len_m1;
  logic              run, adv, dai;
  assign run    = state_q == RUN;
  assign adv    = bus.clken_PC & (bus.incr_PC | bus.load_PC);
  // A zero length counts as one element; >= also catches a length shrunk mid-vector
  assign len_m1 = (bus.vect_len == '0) ? '0 : bus.vect_len - 1'b1;
  assign dai    = run & ~bus.is_not_vect & (elem_q >= len_m1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= START_PC_V;
      elem_q   <= '0;
      end_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      elem_q   <= elem_d;
      end_pc_q <= end_pc_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    elem_d   = elem_q;
    end_pc_d = end_pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d     = START_PC_V;
        elem_d   = '0;
        end_pc_d = bus.end_pc;
        state_d  = bus.start ? RUN : IDLE;
      end
      RUN: begin
        pc_d    = !bus.clken_PC ? pc_q : bus.load_PC ? bus.load_value_PC : bus.incr_PC ? pc_q + 1'b1 : pc_q;
        elem_d  = (bus.is_not_vect || dai) ? '0 : elem_q + 1'b1;
        state_d = (adv && pc_q == end_pc_q) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.pc             = pc_q;
    bus.elem_idx       = elem_q;
    bus.imem_rd_en     = run;
    bus.done_auto_incr = dai;
    bus.busy           = state_q != IDLE;
    bus.done           = state_q == DONE;
  end
`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else if (state_q == IDLE && bus.start) cyc_q <= '0;
    else if (run && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
  end
  assign bus.run_cycles = cyc_q;
`endif
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and vector-element auto-increment counter for a CGRA processing element.
- Consumes the PC control strobes from the PC control logic (clock enable, load, increment, load value) and applies them to the PC.
- Generates the done_auto_incr and element-index signals that the PC control logic and datapath consume.
- Wraps the PC in a start/done run handshake so the host launches a program and sees its completion.

Parameters:
- PC_W, 12, PC width and branch-target width.
- VLEN_W, 8, width of vector length and element index.
- START_PC, 0, PC value loaded on an accepted start.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch pulse; accepted only in IDLE.
- end_pc  in  PC_W  last program address; sampled on an accepted start.
- clken_PC  in  1  PC update enable.
- load_PC  in  1  load PC with load_value_PC.
- incr_PC  in  1  PC+1.
- load_value_PC  in  PC_W  branch target.
- is_not_vect  in  1  current instruction is scalar (0 = vector).
- vect_len  in  VLEN_W  elements in the current vector instruction; 0 is treated as 1.
- pc  out  PC_W  current PC / instruction-memory address.
- imem_rd_en  out  1  instruction fetch enable.
- elem_idx  out  VLEN_W  current vector element index.
- done_auto_incr  out  1  last element of the current vector instruction.
- busy  out  1  state is RUN or DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE, pc=START_PC, elem_idx=0, end_pc_q=0, done=0. busy, imem_rd_en and done_auto_incr are 0.
- State IDLE:
  - start=1 → RUN.
  - pc←START_PC, elem_idx←0, end_pc_q←end_pc.
- State RUN:
  - imem_rd_en=1.
  - PC update applies only when clken_PC=1.
  - load_PC has priority over incr_PC: pc←load_value_PC.
  - Else if incr_PC: pc←pc+1, modulo 2^PC_W (0xFFF wraps to 0x000).
  - Else: hold.
  - clken_PC=0 holds pc regardless of load/incr.
- Vector counter (RUN only):
  - is_not_vect=0: elem_idx increments by 1 per cycle.
  - Effective length L = max(vect_len,1).
  - done_auto_incr = RUN & !is_not_vect & (elem_idx == L-1). Combinational from registers plus is_not_vect; no path from clken/load/incr.
  - On the cycle done_auto_incr=1: elem_idx←0 next cycle.
  - Scalar instruction: elem_idx held at 0.
  - vect_len sampled every cycle. If elem_idx ≥ L (length changed mid-vector), done_auto_incr=1 and elem_idx clears.
- Termination:
  - In RUN, if pc==end_pc_q and the PC logic advances (clken_PC & (incr_PC|load_PC)) → DONE.
  - The final update is still applied to pc.
  - A vector instruction at end_pc_q finishes only on its last element, because clken_PC is low until then.
- State DONE: one cycle; done=1, imem_rd_en=0, → IDLE.
- Start handling: start in RUN or DONE is ignored, not queued.
- Reset mid-run: asynchronous return to the reset values above; no done pulse.
- Latency:
  - start → first fetch (imem_rd_en=1): 1 cycle.
  - Final advance at end_pc → done: 1 cycle.

Optional Feature:
- Macro: PC_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output run_cycles [31:0].
  - Clears on an accepted start and increments every RUN cycle, saturating at 0xFFFFFFFF.
  - Holds its value in DONE/IDLE until the next start; reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset with start=1 held → pc=0, busy=0, done=0. Release rst, start pulse → busy=1 next cycle.
- Scalar run:
  - Stimulus: end_pc=3; is_not_vect=1; clken=1, incr=1 each cycle.
  - Response: pc 0,1,2,3 on consecutive RUN cycles. done=1 one cycle after the pc=3 advance. pc=4 at done, then IDLE.
- Branch: at pc=2 drive load_PC=1, incr_PC=1, load_value=0x00A → pc=0x00A next cycle (load wins). With clken=0, the same strobes leave pc=2.
- Vector:
  - Stimulus: is_not_vect=0, vect_len=4, clken low until done_auto_incr.
  - Response: elem_idx 0,1,2,3; done_auto_incr=1 only at idx 3; idx 0 next cycle.
  - vect_len=0 → done_auto_incr=1 on the first cycle.
- Wrap and ignored start: load 0xFFF, incr → pc=0x000. start pulses during RUN leave pc and state unchanged.
- Async rst asserted mid-vector at elem_idx=2 → pc=0, elem_idx=0 immediately, no done pulse.
- With PC_SEQ_PERF_CNT_EN: 4-instruction scalar run → run_cycles=4, held after done.
